// File: rtl/jtag_scan_seq.sv
// jtag_scan_seq: whole-scan JTAG master; walks a TAP through IR/DR/reset sequences on TCK.
// Latency (accept edge E0 to rsp_valid): DR n bits E0+n+5, IR E0+IR_WIDTH+6, reset E0+6, DR len 0 E0+1.
// Backpressure: one command in flight; cmd_ready stays low until the response has been consumed.
//
// Ports:
//   tck, trst_n          scan clock shared with the TAP, async active-low reset
//   cmd_valid/cmd_ready  command handshake; cmd_is_ir, cmd_reset, cmd_len, cmd_data qualify it
//   rsp_valid/rsp_ready  response handshake; rsp_data holds captured TDO, first bit in [0]
//   tms, tdi, tdo        TAP pins
//
// Optional feature macro: JTAG_SEQ_IDLE_EN adds input cmd_idle[3:0], the number of extra
// Run-Test/Idle cycles spent after a scan before the response is raised.
module jtag_scan_seq #(
   parameter int IR_WIDTH = 8,
   parameter int DR_MAX   = 32,
   parameter int LEN_W    = 6
) (
   input  logic              tck,
   input  logic              trst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_is_ir,
   input  logic              cmd_reset,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic [DR_MAX-1:0] cmd_data,
`ifdef JTAG_SEQ_IDLE_EN
   input  logic [3:0]        cmd_idle,
`endif
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DR_MAX-1:0] rsp_data,
   output logic              tms,
   output logic              tdi,
   input  logic              tdo
);

   // The counter serves both shift lengths and the 4-cycle reset walk.
   localparam int LMAX   = (DR_MAX > IR_WIDTH) ? DR_MAX : IR_WIDTH;
   localparam int CNT_W0 = $clog2(LMAX + 1);
   localparam int CNT_W  = (CNT_W0 < 2) ? 2 : CNT_W0;
   localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);
   localparam logic [CNT_W-1:0] C_RST_LAST = CNT_W'(3);

   typedef enum logic [3:0] {
      S_TLR,
      S_IDLE,
      S_SEL_DR,
      S_SEL_IR,
      S_CAP,
      S_SHIFT,
      S_EXIT1,
      S_UPDATE,
      S_RST
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_go;
   logic                r_is_ir;
   logic                r_is_rst;
   logic                r_rsp_vld;
   logic [CNT_W-1:0]    r_len;
   logic [CNT_W-1:0]    r_cnt;
   logic [DR_MAX-1:0]   r_sh;
   logic [DR_MAX-1:0]   r_cap;

   logic                w_accept;
   logic                w_last;
   logic                w_nop;
   logic                w_finish;
   logic                w_post;
   logic                w_idle_zero;
   logic                w_idle_done;

   assign cmd_ready = (r_state == S_IDLE) && !r_go && !r_rsp_vld;
   assign w_accept  = cmd_valid && cmd_ready;
   assign rsp_valid = r_rsp_vld;
   assign rsp_data  = r_cap;

   assign w_last = (r_cnt == (r_len - C_ONE));
   // A zero-length DR scan completes from IDLE without moving the TAP.
   assign w_nop  = !r_is_ir && !r_is_rst && (r_len == '0);

`ifdef JTAG_SEQ_IDLE_EN
   logic       r_post;
   logic [3:0] r_idle;
   logic [3:0] r_icnt;
   logic       w_post_set;

   assign w_post      = r_post;
   assign w_idle_zero = (r_idle == 4'd0);
   assign w_idle_done = (r_icnt == 4'd1);
   assign w_post_set  = (r_state == S_UPDATE) && !w_idle_zero;

   always_ff @(posedge tck or negedge trst_n) begin
      if (!trst_n) begin
         r_post <= 1'b0;
         r_idle <= 4'd0;
         r_icnt <= 4'd0;
      end else begin
         if (w_accept) begin
            r_idle <= cmd_idle;
         end
         if (w_post_set) begin
            r_post <= 1'b1;
            r_icnt <= r_idle;
         end else if (r_post) begin
            if (w_idle_done) begin
               r_post <= 1'b0;
            end
            r_icnt <= r_icnt - 4'd1;
         end
      end
   end
`else
   assign w_post      = 1'b0;
   assign w_idle_zero = 1'b1;
   assign w_idle_done = 1'b0;
`endif

   always_ff @(posedge tck or negedge trst_n) begin
      if (!trst_n) begin
         r_state <= S_TLR;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state plus TAP pin decode; tms/tdi depend on registers only.
   always_comb begin
      w_state_nxt = r_state;
      w_finish    = 1'b0;
      tms         = 1'b0;
      tdi         = 1'b0;
      case (r_state)
         S_TLR: begin
            w_state_nxt = S_IDLE;
            w_finish    = r_go;      // end of a reset command
         end
         S_IDLE: begin
            if (w_post) begin
               w_finish = w_idle_done;
            end else if (r_go) begin
               if (r_is_rst) begin
                  tms         = 1'b1;
                  w_state_nxt = S_RST;
               end else if (w_nop) begin
                  w_finish = 1'b1;
               end else begin
                  tms         = 1'b1;
                  w_state_nxt = S_SEL_DR;
               end
            end
         end
         S_SEL_DR: begin
            tms         = r_is_ir;
            w_state_nxt = r_is_ir ? S_SEL_IR : S_CAP;
         end
         S_SEL_IR: begin
            w_state_nxt = S_CAP;
         end
         S_CAP: begin
            w_state_nxt = S_SHIFT;
         end
         S_SHIFT: begin
            tms = w_last;
            tdi = r_sh[0];
            if (w_last) begin
               w_state_nxt = S_EXIT1;
            end
         end
         S_EXIT1: begin
            tms         = 1'b1;
            w_state_nxt = S_UPDATE;
         end
         S_UPDATE: begin
            w_state_nxt = S_IDLE;
            w_finish    = w_idle_zero;
         end
         S_RST: begin
            tms = 1'b1;
            if (r_cnt == C_RST_LAST) begin
               w_state_nxt = S_TLR;
            end
         end
         default: begin
            w_state_nxt = S_TLR;
         end
      endcase
   end

   always_ff @(posedge tck or negedge trst_n) begin
      if (!trst_n) begin
         r_go      <= 1'b0;
         r_is_ir   <= 1'b0;
         r_is_rst  <= 1'b0;
         r_rsp_vld <= 1'b0;
         r_len     <= '0;
         r_cnt     <= '0;
         r_sh      <= '0;
         r_cap     <= '0;
      end else begin
         if (r_rsp_vld && rsp_ready) begin
            r_rsp_vld <= 1'b0;
         end
         if (w_accept) begin
            r_go     <= 1'b1;
            r_is_rst <= cmd_reset;
            r_is_ir  <= cmd_is_ir && !cmd_reset;
            r_sh     <= cmd_data;
            r_cap    <= '0;
            if (cmd_reset) begin
               r_len <= '0;
            end else if (cmd_is_ir) begin
               r_len <= CNT_W'(IR_WIDTH);
            end else if (int'(cmd_len) > DR_MAX) begin
               r_len <= CNT_W'(DR_MAX);
            end else begin
               r_len <= CNT_W'(cmd_len);
            end
         end
         if (w_finish) begin
            r_go      <= 1'b0;
            r_rsp_vld <= 1'b1;
         end
         // Counter restarts on every state change; it runs only in SHIFT and RST.
         if (w_state_nxt != r_state) begin
            r_cnt <= '0;
         end else if (r_state == S_SHIFT || r_state == S_RST) begin
            r_cnt <= r_cnt + C_ONE;
         end
         if (r_state == S_SHIFT) begin
            r_sh <= r_sh >> 1;
            for (int i = 0; i < DR_MAX; i++) begin
               if (r_cnt == CNT_W'(i)) begin
                  r_cap[i] <= tdo;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_jtag_scan_seq.sv
// Bench for jtag_scan_seq with a behavioural 8-bit-IR TAP (IDCODE opcode 0x01).
module tb_jtag_scan_seq;

   localparam logic [31:0] IDCODE = 32'h4BA0_0477;

   logic        tck;
   logic        trst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_is_ir;
   logic        cmd_reset;
   logic [5:0]  cmd_len;
   logic [31:0] cmd_data;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        tms;
   logic        tdi;
   logic        tdo;

   int checks = 0;
   int errors = 0;

   jtag_scan_seq #(.IR_WIDTH(8), .DR_MAX(32), .LEN_W(6)) dut (
      .tck       (tck),
      .trst_n    (trst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_is_ir (cmd_is_ir),
      .cmd_reset (cmd_reset),
      .cmd_len   (cmd_len),
      .cmd_data  (cmd_data),
`ifdef JTAG_SEQ_IDLE_EN
      .cmd_idle  (4'd0),
`endif
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .tms       (tms),
      .tdi       (tdi),
      .tdo       (tdo)
   );

   initial begin
      tck = 1'b0;
      forever #5 tck = ~tck;
   end

   // ---------------- behavioural TAP ----------------
   typedef enum logic [3:0] {
      T_TLR, T_RTI, T_SELDR, T_CAPDR, T_SHDR, T_EX1DR, T_PDR, T_EX2DR, T_UPDR,
      T_SELIR, T_CAPIR, T_SHIR, T_EX1IR, T_PIR, T_EX2IR, T_UPIR
   } tap_t;

   tap_t        tap_state;
   logic [7:0]  tap_ir;
   logic [7:0]  tap_irsh;
   logic [31:0] tap_drsh;

   always @(posedge tck or negedge trst_n) begin
      if (!trst_n) begin
         tap_state <= T_TLR;
         tap_ir    <= 8'h01;
         tap_irsh  <= 8'h00;
         tap_drsh  <= 32'h0;
      end else begin
         case (tap_state)
            T_TLR:   tap_state <= tms ? T_TLR   : T_RTI;
            T_RTI:   tap_state <= tms ? T_SELDR : T_RTI;
            T_SELDR: tap_state <= tms ? T_SELIR : T_CAPDR;
            T_CAPDR: tap_state <= tms ? T_EX1DR : T_SHDR;
            T_SHDR:  tap_state <= tms ? T_EX1DR : T_SHDR;
            T_EX1DR: tap_state <= tms ? T_UPDR  : T_PDR;
            T_PDR:   tap_state <= tms ? T_EX2DR : T_PDR;
            T_EX2DR: tap_state <= tms ? T_UPDR  : T_SHDR;
            T_UPDR:  tap_state <= tms ? T_SELDR : T_RTI;
            T_SELIR: tap_state <= tms ? T_TLR   : T_CAPIR;
            T_CAPIR: tap_state <= tms ? T_EX1IR : T_SHIR;
            T_SHIR:  tap_state <= tms ? T_EX1IR : T_SHIR;
            T_EX1IR: tap_state <= tms ? T_UPIR  : T_PIR;
            T_PIR:   tap_state <= tms ? T_EX2IR : T_PIR;
            T_EX2IR: tap_state <= tms ? T_UPIR  : T_SHIR;
            default: tap_state <= tms ? T_SELDR : T_RTI;
         endcase
         if (tap_state == T_TLR)   tap_ir   <= 8'h01;
         if (tap_state == T_CAPIR) tap_irsh <= 8'h01;
         if (tap_state == T_SHIR)  tap_irsh <= {tdi, tap_irsh[7:1]};
         if (tap_state == T_UPIR)  tap_ir   <= tap_irsh;
         if (tap_state == T_CAPDR) tap_drsh <= (tap_ir == 8'h01) ? IDCODE : 32'h0;
         if (tap_state == T_SHDR)  tap_drsh <= {tdi, tap_drsh[31:1]};
      end
   end

   always @(negedge tck or negedge trst_n) begin
      if (!trst_n) tdo <= 1'b0;
      else         tdo <= (tap_state == T_SHDR) ? tap_drsh[0] :
                          (tap_state == T_SHIR) ? tap_irsh[0] : 1'b0;
   end

   // Per-cycle log, index k = negedge following accept edge E0+k.
   logic tms_log [0:127];
   logic tdi_log [0:127];
   tap_t tap_log [0:127];

   // Drives one command, logs pins until rsp_valid, then consumes the response.
   task automatic run_cmd(input logic ir, input logic rs, input logic [5:0] len,
                          input logic [31:0] dat, output int lat, output logic [31:0] rdat);
      int w;
      lat  = -1;
      rdat = '0;
      w    = 0;
      while (cmd_ready !== 1'b1 && w < 50) begin
         @(negedge tck);
         w++;
      end
      if (cmd_ready !== 1'b1) return;
      cmd_valid = 1'b1;
      cmd_is_ir = ir;
      cmd_reset = rs;
      cmd_len   = len;
      cmd_data  = dat;
      @(posedge tck);
      for (int k = 0; k < 100; k++) begin
         @(negedge tck);
         cmd_valid  = 1'b0;
         tms_log[k] = tms;
         tdi_log[k] = tdi;
         tap_log[k] = tap_state;
         if (rsp_valid === 1'b1) begin
            lat  = k;
            rdat = rsp_data;
            break;
         end
      end
      if (lat >= 0) begin
         rsp_ready = 1'b1;
         @(posedge tck);
         @(negedge tck);
         rsp_ready = 1'b0;
      end
   endtask

   task automatic test_reset;
      trst_n = 1'b0;
      repeat (2) @(negedge tck);
      #1;
      checks++; if (tms !== 1'b0)       begin errors++; $display("FAIL reset_tms: got %b want 0", tms); end
      checks++; if (tdi !== 1'b0)       begin errors++; $display("FAIL reset_tdi: got %b want 0", tdi); end
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
      checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
      trst_n = 1'b1;
      #1;
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL release_ready_early: got %b want 0", cmd_ready); end
      @(negedge tck);
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL release_ready_1edge: got %b want 1", cmd_ready); end
      checks++; if (tms !== 1'b0)       begin errors++; $display("FAIL release_tms: got %b want 0", tms); end
   endtask

   task automatic test_ir_idcode;
      int          lat;
      logic [31:0] rdat;
      logic [13:0] got_tms;
      logic [7:0]  got_tdi;
      run_cmd(1'b1, 1'b0, 6'd0, 32'h0000_0001, lat, rdat);
      for (int i = 0; i < 14; i++) got_tms[i] = tms_log[i];
      for (int i = 0; i < 8; i++)  got_tdi[i] = tdi_log[4 + i];
      checks++; if (lat !== 14)          begin errors++; $display("FAIL ir_latency: got %0d want 14", lat); end
      checks++; if (got_tms !== 14'h1803) begin errors++; $display("FAIL ir_tms_seq: got %h want 1803", got_tms); end
      checks++; if (got_tdi !== 8'h01)   begin errors++; $display("FAIL ir_tdi: got %h want 01", got_tdi); end
      checks++; if (rdat !== 32'h1)      begin errors++; $display("FAIL ir_capture: got %h want 00000001", rdat); end
   endtask

   task automatic test_dr_idcode;
      int          lat;
      logic [31:0] rdat;
      logic [36:0] got_tms;
      logic [31:0] got_tdi;
      run_cmd(1'b0, 1'b0, 6'd32, 32'hA5C3_0F1E, lat, rdat);
      for (int i = 0; i < 37; i++) got_tms[i] = tms_log[i];
      for (int i = 0; i < 32; i++) got_tdi[i] = tdi_log[3 + i];
      checks++; if (lat !== 37)                 begin errors++; $display("FAIL dr_latency: got %0d want 37", lat); end
      checks++; if (got_tms !== 37'h0C_0000_0001) begin errors++; $display("FAIL dr_tms_seq: got %h want 0c00000001", got_tms); end
      checks++; if (got_tdi !== 32'hA5C3_0F1E)  begin errors++; $display("FAIL dr_tdi_replay: got %h want a5c30f1e", got_tdi); end
      checks++; if (rdat !== IDCODE)            begin errors++; $display("FAIL dr_idcode: got %h want %h", rdat, IDCODE); end
      checks++; if (tap_drsh !== 32'hA5C3_0F1E) begin errors++; $display("FAIL dr_tap_shifted: got %h want a5c30f1e", tap_drsh); end
   endtask

   task automatic test_reset_cmd;
      int          lat;
      logic [31:0] rdat;
      logic [5:0]  got_tms;
      run_cmd(1'b1, 1'b1, 6'd5, 32'hFFFF_FFFF, lat, rdat);
      for (int i = 0; i < 6; i++) got_tms[i] = tms_log[i];
      checks++; if (lat !== 6)           begin errors++; $display("FAIL rstcmd_latency: got %0d want 6", lat); end
      checks++; if (got_tms !== 6'h1F)   begin errors++; $display("FAIL rstcmd_tms_seq: got %h want 1f", got_tms); end
      checks++; if (tap_log[5] !== T_TLR) begin errors++; $display("FAIL rstcmd_tap_tlr: got %0d want %0d", tap_log[5], T_TLR); end
      checks++; if (rdat !== 32'h0)      begin errors++; $display("FAIL rstcmd_data: got %h want 0", rdat); end
   endtask

   task automatic test_dr_clamp;
      int          lat;
      logic [31:0] rdat;
      run_cmd(1'b0, 1'b0, 6'd40, 32'h0F0F_3355, lat, rdat);
      checks++; if (lat !== 37)                 begin errors++; $display("FAIL clamp_latency: got %0d want 37", lat); end
      checks++; if (rdat !== IDCODE)            begin errors++; $display("FAIL clamp_data: got %h want %h", rdat, IDCODE); end
      checks++; if (tap_drsh !== 32'h0F0F_3355) begin errors++; $display("FAIL clamp_tap_shifted: got %h want 0f0f3355", tap_drsh); end
   endtask

   task automatic test_dr_zero;
      int          lat;
      logic [31:0] rdat;
      run_cmd(1'b0, 1'b0, 6'd0, 32'hDEAD_BEEF, lat, rdat);
      checks++; if (lat !== 1)            begin errors++; $display("FAIL zero_latency: got %0d want 1", lat); end
      checks++; if (tms_log[0] !== 1'b0)  begin errors++; $display("FAIL zero_tms: got %b want 0", tms_log[0]); end
      checks++; if (tap_log[1] !== T_RTI) begin errors++; $display("FAIL zero_tap_moved: got %0d want %0d", tap_log[1], T_RTI); end
      checks++; if (rdat !== 32'h0)       begin errors++; $display("FAIL zero_data: got %h want 0", rdat); end
   endtask

   task automatic test_trst_mid;
      int          w;
      int          lat;
      logic        seen;
      logic [31:0] rdat;
      w = 0;
      while (cmd_ready !== 1'b1 && w < 50) begin
         @(negedge tck);
         w++;
      end
      cmd_valid = 1'b1;
      cmd_is_ir = 1'b0;
      cmd_reset = 1'b0;
      cmd_len   = 6'd32;
      cmd_data  = 32'hCAFE_F00D;
      @(posedge tck);
      @(negedge tck);
      cmd_valid = 1'b0;
      repeat (10) @(negedge tck);
      checks++; if (tap_state !== T_SHDR) begin errors++; $display("FAIL trst_in_shift: tap %0d want %0d", tap_state, T_SHDR); end
      trst_n = 1'b0;
      #1;
      checks++; if (tms !== 1'b0)       begin errors++; $display("FAIL trst_tms: got %b want 0", tms); end
      checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL trst_rsp_data: got %h want 0", rsp_data); end
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL trst_cmd_ready: got %b want 0", cmd_ready); end
      @(negedge tck);
      trst_n = 1'b1;
      @(negedge tck);
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL trst_ready_after: got %b want 1", cmd_ready); end
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge tck);
         if (rsp_valid !== 1'b0) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL trst_no_rsp: rsp_valid seen %b want 0", seen); end
      run_cmd(1'b0, 1'b0, 6'd32, 32'h1357_9BDF, lat, rdat);
      checks++; if (lat !== 37)      begin errors++; $display("FAIL trst_next_latency: got %0d want 37", lat); end
      checks++; if (rdat !== IDCODE) begin errors++; $display("FAIL trst_next_data: got %h want %h", rdat, IDCODE); end
   endtask

   task automatic test_back_to_back;
      int w;
      int k1;
      int k2;
      w = 0;
      while (cmd_ready !== 1'b1 && w < 50) begin
         @(negedge tck);
         w++;
      end
      cmd_valid = 1'b1;
      cmd_is_ir = 1'b0;
      cmd_reset = 1'b0;
      cmd_len   = 6'd8;
      cmd_data  = 32'h0000_00A5;
      @(posedge tck);
      k1 = -1;
      for (int j = 0; j < 100; j++) begin
         @(negedge tck);
         cmd_valid = 1'b0;
         if (rsp_valid === 1'b1) begin
            k1 = j;
            break;
         end
      end
      checks++; if (k1 !== 13)            begin errors++; $display("FAIL b2b_first_latency: got %0d want 13", k1); end
      checks++; if (rsp_data !== 32'h77)  begin errors++; $display("FAIL b2b_first_data: got %h want 00000077", rsp_data); end
      // Response consume and next command offered in the same cycle.
      rsp_ready = 1'b1;
      cmd_valid = 1'b1;
      cmd_len   = 6'd4;
      cmd_data  = 32'h0000_0009;
      @(posedge tck);
      @(negedge tck);
      rsp_ready = 1'b0;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_rsp_dropped: got %b want 0", rsp_valid); end
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_no_overlap_accept: ready %b want 1", cmd_ready); end
      @(posedge tck);
      @(negedge tck);
      cmd_valid = 1'b0;
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept_next: ready %b want 0", cmd_ready); end
      k2 = -1;
      for (int j = 1; j < 100; j++) begin
         @(negedge tck);
         if (rsp_valid === 1'b1) begin
            k2 = j;
            break;
         end
      end
      checks++; if (k2 !== 9)            begin errors++; $display("FAIL b2b_second_latency: got %0d want 9", k2); end
      checks++; if (rsp_data !== 32'h7)  begin errors++; $display("FAIL b2b_second_data: got %h want 00000007", rsp_data); end
      rsp_ready = 1'b1;
      @(posedge tck);
      @(negedge tck);
      rsp_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      trst_n    = 1'b0;
      cmd_valid = 1'b0;
      cmd_is_ir = 1'b0;
      cmd_reset = 1'b0;
      cmd_len   = 6'd0;
      cmd_data  = 32'h0;
      rsp_ready = 1'b0;
      test_reset();
      test_ir_idcode();
      test_dr_idcode();
      test_reset_cmd();
      test_dr_clamp();
      test_dr_zero();
      test_trst_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/jtag_scan_seq.md
# jtag_scan_seq

JTAG scan sequencer that drives the TMS/TDI pins of an on-chip TAP controller (DW_tap_uc-style, `width`-bit instruction register) and collects TDO. It runs on the same TCK as the TAP and accepts whole-scan commands over a valid/ready interface. For each command it walks the TAP state machine and returns the shifted-out data on a response handshake. It is the test-access master for bring-up and BIST sequencing.

## Interface
- `IR_WIDTH`, default 8: TAP instruction register length; every IR scan shifts exactly this many bits.
- `DR_MAX`, default 32: maximum DR scan length and the width of the data buses.
- `LEN_W`, default 6: width of `cmd_len`; must be at least clog2(DR_MAX+1).
- `tck` input 1: scan clock, shared with the TAP; all state updates on the rising edge.
- `trst_n` input 1: asynchronous active-low reset.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: sequencer can accept a command.
- `cmd_is_ir` input 1: 1 = IR scan, 0 = DR scan.
- `cmd_reset` input 1: 1 = TAP reset sequence; takes priority over `cmd_is_ir`.
- `cmd_len` input LEN_W: DR scan length; ignored for IR and reset commands.
- `cmd_data` input DR_MAX: TDI data, LSB shifted first.
- `rsp_valid` output 1: response available.
- `rsp_ready` input 1: response consumed.
- `rsp_data` output DR_MAX: captured TDO, first bit in [0]; bits at or above the scan length are 0.
- `tms` output 1: to TAP `tms`.
- `tdi` output 1: to TAP `tdi`.
- `tdo` input 1: from TAP `tdo`.

## Operation
- Internal state mirrors the TAP state: TLR, IDLE, SEL_DR, SEL_IR, CAP, SHIFT, EXIT1, UPDATE, plus RST for the reset sequence. `tms` and `tdi` are decoded from registered state only, with no combinational path from the inputs.
- Reset values: state TLR, `tms`=0, `tdi`=0, `cmd_ready`=0, `rsp_valid`=0, `rsp_data`=0, go flag 0.
- TLR drives `tms`=0 and moves to IDLE on the next edge.
- `cmd_ready` = (state==IDLE) && !go && !`rsp_valid`.
- Accept (`cmd_valid` && `cmd_ready`):
  - latch the command;
  - clamp the length: a DR length above DR_MAX becomes DR_MAX; IR uses IR_WIDTH;
  - set go.
- IDLE drives `tms`=1 when go=1, otherwise 0.
- DR scan path and `tms` values: IDLE(1) → SEL_DR(0) → CAP(0) → SHIFT (0 for n-1 cycles, 1 on the last) → EXIT1(1) → UPDATE(0) → IDLE.
- IR scan path: same as DR, but with SEL_DR(1) → SEL_IR(0) inserted before CAP.
- In SHIFT:
  - `tdi` = data bit k during the k-th SHIFT cycle;
  - `tdo` is sampled on every rising edge leaving a SHIFT cycle and stored at bit k.
- Reset command: IDLE(1) → RST ×4 (`tms`=1) → TLR(0) → IDLE. `rsp_data`=0.
- DR command with `cmd_len`=0: accepted as a no-op with no TAP movement. `rsp_valid` rises on the edge after accept, and `rsp_data`=0.
- On entry to IDLE from UPDATE or TLR while go=1: clear go, set `rsp_valid`. Data and `rsp_valid` are held until `rsp_valid` && `rsp_ready`.
- `trst_n` asserted mid-scan: immediate return to reset values. Partial capture is discarded and no response is issued.

## Timing
- Accept edge E0. The edge that raises `rsp_valid` is:
  - DR: E0+n+5;
  - IR: E0+IR_WIDTH+6;
  - reset: E0+6.
- SHIFT occupies edges E0+3 .. E0+2+n for DR, and one edge later for IR. TDO is captured on edges E0+4 .. E0+3+n for DR.
- After release of `trst_n`, the first `cmd_ready`=1 is seen after one rising edge (TLR→IDLE).
- A response handshake completing on edge Ek gives `cmd_ready`=1 after Ek. A back-to-back command accepts at Ek+1 at the earliest, so `rsp_ready` and `cmd_valid` in the same cycle never overlap an accept.

## Configuration
- `JTAG_SEQ_IDLE_EN` defined:
  - adds input `cmd_idle` [3:0], latched at accept;
  - after UPDATE→IDLE (scan commands only), the block stays in IDLE with `tms`=0 for `cmd_idle` extra cycles, then raises `rsp_valid`;
  - scan latency grows by `cmd_idle`.
- `JTAG_SEQ_IDLE_EN` undefined: the port is absent and `rsp_valid` rises on IDLE entry, giving the latencies above.

## Test plan
- Release `trst_n` → `tms`=0, `cmd_ready` rises after 1 edge, `rsp_valid`=0, outputs at reset values.
- IR scan, `cmd_data`=0x01 (IDCODE opcode), IR_WIDTH=8:
  - TMS sequence 1,1,0,0,0×7,1,1,0;
  - `rsp_valid` at E0+14;
  - `rsp_data`[1:0]=2'b01 (IR capture pattern).
- DR scan of 32 bits after IDCODE IR:
  - `rsp_valid` at E0+37;
  - `rsp_data` = the TAP's 32-bit ID with bit0=1;
  - `tdi` replays `cmd_data` LSB first.
- Reset command → `tms`=1 for 5 consecutive cycles, then 0; TAP `tap_state` shows Test-Logic-Reset; `rsp_data`=0.
- DR with `cmd_len`=40 → clamped to 32 shift cycles; DR with `cmd_len`=0 → `rsp_valid` on the edge after accept, `tms` stays 0.
- `trst_n` pulsed during SHIFT of a 32-bit DR scan → state returns to TLR, `rsp_valid` is never raised, and the next command completes normally.
